stream_width_down: RTL and testbench
====================================

// Module: stream_width_down
// PURPOSE
//   Reader-side stream gearbox. Pops width_p-bit words from a valid/ready source
//   (typically the read port of a 1r1w FIFO) and replays each word as ratio_p
//   narrower beats on a valid/ready sink. Runs in a single clock domain and
//   drains a FIFO read interface into a narrower datapath.
// PARAMETERS
//   width_p      32  input word width; must be divisible by ratio_p
//   ratio_p       4  beats per input word; >= 2 (output width = width_p/ratio_p)
//   msb_first_p   0  0: beat 0 = data[nw-1:0] (LSB first); 1: beat 0 = MSB slice
// PORTS
//   clk_i     in   1              clock; all state updates on posedge
//   reset_i   in   1              asynchronous, active-high reset
//   valid_i   in   1              input word valid
//   data_i    in   width_p        input word
//   ready_o   out  1              block accepts a word this cycle
//   valid_o   out  1              output beat valid
//   data_o    out  width_p/ratio_p  output beat
//   last_o    out  1              current output beat is the final slice of its word
//   ready_i   in   1              downstream accepts the beat this cycle
// BEHAVIOUR
//   - nw = width_p/ratio_p. Beat counter cnt_r is max(1,$clog2(ratio_p)) bits wide.
//   - Reset (async assert, sampled release): state=EMPTY, cnt_r=0, word_r=0;
//     valid_o=0, last_o=0, data_o=0, ready_o=1.
//   - State EMPTY: valid_o=0, ready_o=1. On valid_i: load word_r<=data_i,
//     cnt_r<=0, go to BUSY. Latency: input accepted in cycle N -> beat 0 valid in N+1.
//   - State BUSY: valid_o=1; data_o = slice cnt_r of word_r (slice k = bits
//     [k*nw +: nw] if msb_first_p=0, else [(ratio_p-1-k)*nw +: nw]).
//     last_o = (cnt_r == ratio_p-1). Beat transfers when valid_o && ready_i.
//     * Transfer, not last: cnt_r<=cnt_r+1, stay BUSY.
//     * Transfer on last: ready_o=1 combinationally this cycle; if valid_i,
//       load next word, cnt_r<=0, stay BUSY (back-to-back, no bubble);
//       else go EMPTY.
//     * No transfer: hold word_r, cnt_r, data_o, last_o stable (AXI-style hold).
//   - ready_o = (state==EMPTY) || (state==BUSY && last_o && ready_i).
//     ready_o depends combinationally on ready_i; no path from valid_i to ready_o.
//   - valid_o never depends combinationally on valid_i or ready_i.
//   - Steady-state throughput: 1 beat/cycle; 1 word per ratio_p cycles.
//   - Counter never exceeds ratio_p-1; for non-power-of-2 ratio_p it is reset
//     to 0 on reload, never wraps through unused codes.
//   - data_i sampled only on accept; changes on valid_i without ready_o ignored.
//   - Reset mid-word: in-flight word discarded, outputs go to reset values
//     immediately (async); no partial word emitted after release.
//   - Elaboration error if width_p % ratio_p != 0 or ratio_p < 2.
// TESTING
//   1. Reset: reset_i=1 mid-BUSY -> same cycle valid_o=0, last_o=0, ready_o=1;
//      after release first accepted word starts at beat 0.
//   2. Single word, ready_i=1, 32/4, LSB first: data_i=32'hDDCCBBAA ->
//      data_o AA,BB,CC,DD on 4 consecutive cycles, last_o only on DD, ready_o
//      high in DD cycle.
//   3. Back-to-back: words 32'h03020100, 32'h07060504 held valid, ready_i=1 ->
//      8 contiguous beats 00..07, no idle cycle between 03 and 04.
//   4. Backpressure: ready_i low for 3 cycles on beat 2 of 32'h44332211 ->
//      data_o=33 held, valid_o=1, ready_o=0 throughout; sequence resumes 33,44.
//   5. msb_first_p=1, data_i=32'hDDCCBBAA -> beats DD,CC,BB,AA, last_o on AA.
//   6. Random valid_i/ready_i stall pattern, 1000 words vs scoreboard ->
//      every slice delivered once in order, no drop or duplicate; ratio_p=3,
//      width_p=24 also exercised.

Source files
------------

// File: rtl/stream_width_down.sv
// rtl/stream_width_down.sv - reader-side gearbox: pops wide words, replays each as ratio_p narrow beats
module stream_width_down #(
  parameter int width_p     = 32,
  parameter int ratio_p     = 4,
  parameter int msb_first_p = 0
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         valid_i,
  input  logic [width_p-1:0]           data_i,
  output logic                         ready_o,
  output logic                         valid_o,
  output logic [width_p/ratio_p-1:0]   data_o,
  output logic                         last_o,
  input  logic                         ready_i
);

  localparam int nw    = width_p / ratio_p;
  localparam int cnt_w = ($clog2(ratio_p) > 1) ? $clog2(ratio_p) : 1;
  localparam logic [cnt_w-1:0] last_cnt = cnt_w'(ratio_p - 1);

  localparam logic [0:0] st_empty = 1'b0;
  localparam logic [0:0] st_busy  = 1'b1;

  if ((width_p % ratio_p) != 0 || ratio_p < 2) begin : g_bad_params
    $error("stream_width_down: width_p must be a multiple of ratio_p and ratio_p >= 2");
  end

  logic [0:0]         state_r;
  logic [cnt_w-1:0]   cnt_r;
  logic [width_p-1:0] word_r;
  logic               busy;
  logic               xfer;
  logic               accept;

  assign busy    = (state_r == st_busy);
  assign valid_o = busy;
  assign last_o  = busy && (cnt_r == last_cnt);
  assign xfer    = busy && ready_i;
  // Only a finishing last beat frees the word register, so ready_o never looks at valid_i.
  assign ready_o = !busy || (last_o && ready_i);
  assign accept  = valid_i && ready_o;

  always_comb begin
    data_o = '0;
    for (int k = 0; k < ratio_p; k++) begin
      if (cnt_r == cnt_w'(k)) begin
        data_o = word_r[((msb_first_p != 0) ? (ratio_p - 1 - k) : k) * nw +: nw];
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= st_empty;
      cnt_r   <= '0;
      word_r  <= '0;
    end else if (accept) begin
      word_r  <= data_i;
      cnt_r   <= '0;
      state_r <= st_busy;
    end else if (xfer) begin
      if (last_o) begin
        state_r <= st_empty;
        cnt_r   <= '0;
      end else begin
        cnt_r <= cnt_r + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stream_width_down.sv
// tb/tb_stream_width_down.sv - directed and randomized-stall checks of stream_width_down
module tb_stream_width_down;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        a_valid_i, a_ready_o, a_valid_o, a_last_o, a_ready_i;
  logic [31:0] a_data_i;
  logic [7:0]  a_data_o;
  logic        m_valid_i, m_ready_o, m_valid_o, m_last_o, m_ready_i;
  logic [31:0] m_data_i;
  logic [7:0]  m_data_o;
  logic        c_valid_i, c_ready_o, c_valid_o, c_last_o, c_ready_i;
  logic [23:0] c_data_i;
  logic [7:0]  c_data_o;

  stream_width_down #(.width_p(32), .ratio_p(4), .msb_first_p(0)) dut_a (
    .clk_i(clk), .reset_i(rst), .valid_i(a_valid_i), .data_i(a_data_i), .ready_o(a_ready_o),
    .valid_o(a_valid_o), .data_o(a_data_o), .last_o(a_last_o), .ready_i(a_ready_i));

  stream_width_down #(.width_p(32), .ratio_p(4), .msb_first_p(1)) dut_m (
    .clk_i(clk), .reset_i(rst), .valid_i(m_valid_i), .data_i(m_data_i), .ready_o(m_ready_o),
    .valid_o(m_valid_o), .data_o(m_data_o), .last_o(m_last_o), .ready_i(m_ready_i));

  stream_width_down #(.width_p(24), .ratio_p(3), .msb_first_p(0)) dut_c (
    .clk_i(clk), .reset_i(rst), .valid_i(c_valid_i), .data_i(c_data_i), .ready_o(c_ready_o),
    .valid_o(c_valid_o), .data_o(c_data_o), .last_o(c_last_o), .ready_i(c_ready_i));

  task automatic test_reset();
    rst = 1'b1;
    a_valid_i = 0; a_data_i = '0; a_ready_i = 1;
    m_valid_i = 0; m_data_i = '0; m_ready_i = 1;
    c_valid_i = 0; c_data_i = '0; c_ready_i = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (a_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", a_valid_o); end
    total++; if (a_last_o !== 1'b0) begin bad++; $display("FAIL reset_last got=%b exp=0", a_last_o); end
    total++; if (a_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", a_ready_o); end
    total++; if (a_data_o !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", a_data_o); end
    @(posedge clk); #1 rst = 1'b0;
    a_valid_i = 1; a_data_i = 32'hDDCCBBAA;
    @(posedge clk); #1 a_valid_i = 0;
    @(posedge clk); #1;
    total++; if (a_data_o !== 8'hBB) begin bad++; $display("FAIL reset_pre_beat1 got=%h exp=bb", a_data_o); end
    #2 rst = 1'b1;
    #1;
    total++; if (a_valid_o !== 1'b0) begin bad++; $display("FAIL reset_mid_valid got=%b exp=0", a_valid_o); end
    total++; if (a_last_o !== 1'b0) begin bad++; $display("FAIL reset_mid_last got=%b exp=0", a_last_o); end
    total++; if (a_ready_o !== 1'b1) begin bad++; $display("FAIL reset_mid_ready got=%b exp=1", a_ready_o); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    total++; if (a_valid_o !== 1'b0) begin bad++; $display("FAIL reset_after_valid got=%b exp=0", a_valid_o); end
    @(posedge clk); #1 a_valid_i = 1; a_data_i = 32'h55667788;
    @(posedge clk); #1 a_valid_i = 0;
    @(negedge clk);
    total++; if (a_data_o !== 8'h88 || a_valid_o !== 1'b1) begin
      bad++; $display("FAIL reset_first_beat got=%h/%b exp=88/1", a_data_o, a_valid_o); end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    logic [7:0] exp [4];
    exp[0] = 8'hAA; exp[1] = 8'hBB; exp[2] = 8'hCC; exp[3] = 8'hDD;
    a_valid_i = 1; a_data_i = 32'hDDCCBBAA; a_ready_i = 1;
    @(negedge clk);
    total++; if (a_ready_o !== 1'b1 || a_valid_o !== 1'b0) begin
      bad++; $display("FAIL single_idle got=rdy%b/vld%b exp=rdy1/vld0", a_ready_o, a_valid_o); end
    @(posedge clk); #1 a_valid_i = 0; a_data_i = 32'hFFFFFFFF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++; if (a_valid_o !== 1'b1 || a_data_o !== exp[k] || a_last_o !== (k == 3) || a_ready_o !== (k == 3)) begin
        bad++; $display("FAIL single_beat%0d got=v%b d%h l%b r%b exp=v1 d%h l%b r%b",
                        k, a_valid_o, a_data_o, a_last_o, a_ready_o, exp[k], (k == 3), (k == 3)); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    total++; if (a_valid_o !== 1'b0) begin bad++; $display("FAIL single_drained got=%b exp=0", a_valid_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    a_valid_i = 1; a_data_i = 32'h03020100; a_ready_i = 1;
    @(posedge clk); #1 a_data_i = 32'h07060504;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++; if (a_valid_o !== 1'b1 || a_data_o !== 8'(i) || a_last_o !== (i == 3 || i == 7)) begin
        bad++; $display("FAIL b2b_beat%0d got=v%b d%h l%b exp=v1 d%h l%b",
                        i, a_valid_o, a_data_o, a_last_o, 8'(i), (i == 3 || i == 7)); end
      @(posedge clk); #1;
      if (i == 3) a_valid_i = 0;
    end
    @(negedge clk);
    total++; if (a_valid_o !== 1'b0) begin bad++; $display("FAIL b2b_drained got=%b exp=0", a_valid_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    a_valid_i = 1; a_data_i = 32'h44332211; a_ready_i = 1;
    @(posedge clk); #1 a_valid_i = 0;
    @(negedge clk);
    total++; if (a_data_o !== 8'h11) begin bad++; $display("FAIL bp_beat0 got=%h exp=11", a_data_o); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (a_data_o !== 8'h22) begin bad++; $display("FAIL bp_beat1 got=%h exp=22", a_data_o); end
    @(posedge clk); #1 a_ready_i = 0; a_valid_i = 1; a_data_i = 32'hEEEEEEEE;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      total++; if (a_data_o !== 8'h33 || a_valid_o !== 1'b1 || a_ready_o !== 1'b0 || a_last_o !== 1'b0) begin
        bad++; $display("FAIL bp_stall%0d got=d%h v%b r%b l%b exp=d33 v1 r0 l0", s, a_data_o, a_valid_o, a_ready_o, a_last_o); end
      @(posedge clk); #1;
    end
    a_ready_i = 1; a_valid_i = 0;
    @(negedge clk);
    total++; if (a_data_o !== 8'h33) begin bad++; $display("FAIL bp_resume33 got=%h exp=33", a_data_o); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (a_data_o !== 8'h44 || a_last_o !== 1'b1) begin
      bad++; $display("FAIL bp_resume44 got=d%h l%b exp=d44 l1", a_data_o, a_last_o); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (a_valid_o !== 1'b0) begin bad++; $display("FAIL bp_drained got=%b exp=0", a_valid_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_msb_first();
    logic [7:0] exp [4];
    exp[0] = 8'hDD; exp[1] = 8'hCC; exp[2] = 8'hBB; exp[3] = 8'hAA;
    m_valid_i = 1; m_data_i = 32'hDDCCBBAA; m_ready_i = 1;
    @(posedge clk); #1 m_valid_i = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++; if (m_valid_o !== 1'b1 || m_data_o !== exp[k] || m_last_o !== (k == 3)) begin
        bad++; $display("FAIL msb_beat%0d got=v%b d%h l%b exp=v1 d%h l%b",
                        k, m_valid_o, m_data_o, m_last_o, exp[k], (k == 3)); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random(input int sel, input int nwords);
    int          ratio;
    int          sent;
    int          cyc;
    bit          pend;
    bit          rdy;
    logic [31:0] word;
    logic [8:0]  q [$];
    logic [8:0]  e;
    logic        r_o, v_o, l_o;
    logic [7:0]  d_o;
    ratio = (sel == 0) ? 4 : 3;
    sent = 0; cyc = 0; pend = 0; word = '0;
    while ((sent < nwords || q.size() > 0) && cyc < 40000) begin
      @(posedge clk); #1;
      if (!pend && sent < nwords && $urandom_range(0, 3) != 0) begin
        word = $urandom;
        if (sel != 0) word[31:24] = 8'h00;
        pend = 1;
      end
      rdy = ($urandom_range(0, 3) != 0);
      if (sel == 0) begin
        a_valid_i = pend; a_data_i = pend ? word : $urandom; a_ready_i = rdy;
      end else begin
        c_valid_i = pend; c_data_i = pend ? word[23:0] : 24'($urandom); c_ready_i = rdy;
      end
      @(negedge clk);
      if (sel == 0) begin r_o = a_ready_o; v_o = a_valid_o; l_o = a_last_o; d_o = a_data_o; end
      else          begin r_o = c_ready_o; v_o = c_valid_o; l_o = c_last_o; d_o = c_data_o; end
      if (pend && r_o) begin
        for (int k = 0; k < ratio; k++) q.push_back({(k == ratio - 1), word[k*8 +: 8]});
        pend = 0;
        sent++;
      end
      if (v_o && rdy) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rand%0d_extra got=d%h l%b exp=no beat", sel, d_o, l_o);
        end else begin
          e = q.pop_front();
          if ({l_o, d_o} !== e) begin
            bad++; $display("FAIL rand%0d_beat got=d%h l%b exp=d%h l%b", sel, d_o, l_o, e[7:0], e[8]); end
        end
      end
      cyc++;
    end
    total++;
    if (sent != nwords || q.size() != 0) begin
      bad++; $display("FAIL rand%0d_timeout got=sent%0d pending%0d exp=sent%0d pending0", sel, sent, q.size(), nwords);
    end
    @(posedge clk); #1;
    if (sel == 0) begin a_valid_i = 0; a_ready_i = 1; end
    else          begin c_valid_i = 0; c_ready_i = 1; end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_msb_first();
    test_random(0, 1000);
    test_random(1, 300);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
